seg_scan_ctrl: RTL

- Memory-mapped controller that drives the 8-digit multiplexed seven-segment display behind the store-address decoder.
- Accepts the Seg write strobe at 0x804 and a control-register strobe, and time-multiplexes digit anodes with a prescaler and scan counter.
- Shadow-buffers the displayed value so updates take effect only at a frame boundary, giving tear-free display.

---
 rtl/seg_scan_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Scan controller for an 8-digit multiplexed seven-segment display.
// Display data is shadow-buffered and committed only at frame boundaries.
module seg_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned DIGITS   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seg_we,
  input  logic        ctrl_we,
  input  logic [31:0] wdata,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done,
  output logic        pending
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned DW = $clog2(DIGITS);

  // Only the decoded control fields are kept; the remaining bits have no effect.
  logic              enable_q, enable_d;
  logic              lzs_q, lzs_d;
  logic [7:0]        dp_mask_q, dp_mask_d;

  logic [PW-1:0]     presc_q, presc_d;
  logic [DW-1:0]     digit_q, digit_d;
  logic [31:0]       active_q, active_d;
  logic [31:0]       pend_val_q, pend_val_d;
  logic              pending_q, pending_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        an_q, an_d;
  logic [7:0]        seg_q, seg_d;

  logic              tick;
  logic              boundary;
  logic [3:0]        nib;
  logic              blank;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h40;
      4'h1: p = 7'h79;
      4'h2: p = 7'h24;
      4'h3: p = 7'h30;
      4'h4: p = 7'h19;
      4'h5: p = 7'h12;
      4'h6: p = 7'h02;
      4'h7: p = 7'h78;
      4'h8: p = 7'h00;
      4'h9: p = 7'h10;
      4'hA: p = 7'h08;
      4'hB: p = 7'h03;
      4'hC: p = 7'h46;
      4'hD: p = 7'h21;
      4'hE: p = 7'h06;
      default: p = 7'h0E;
    endcase
    return p;
  endfunction

  assign tick     = (presc_q == PW'(SCAN_DIV - 1));
  assign boundary = tick && (digit_q == DW'(DIGITS - 1));

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
    presc_d      = tick ? '0 : presc_q + PW'(1);
    digit_d      = tick ? ((digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + DW'(1)) : digit_q;
    frame_done_d = boundary;

    enable_d  = enable_q;
    lzs_d     = lzs_q;
    dp_mask_d = dp_mask_q;
    if (ctrl_we) begin
      enable_d  = wdata[0];
      lzs_d     = wdata[1];
      dp_mask_d = wdata[15:8];
    end

    active_d   = active_q;
    pend_val_d = pend_val_q;
    pending_d  = pending_q;
    if (seg_we && boundary) begin
      // A write landing exactly on the boundary bypasses the shadow register.
      active_d  = wdata;
      pending_d = 1'b0;
    end else if (seg_we) begin
      pend_val_d = wdata;
      pending_d  = 1'b1;
    end else if (boundary && pending_q) begin
      active_d  = pend_val_q;
      pending_d = 1'b0;
    end

    nib   = active_q[{digit_q, 2'b00} +: 4];
    blank = lzs_q && (digit_q != '0) && ((active_q >> {digit_q, 2'b00}) == 32'h0);

    if (enable_q) begin
      an_d  = ~(8'b1 << digit_q);
      seg_d = {~dp_mask_q[digit_q], blank ? 7'h7F : hex7(nib)};
    end else begin
      an_d  = 8'hFF;
      seg_d = 8'hFF;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q     <= 1'b1;
      lzs_q        <= 1'b0;
      dp_mask_q    <= 8'h00;
      presc_q      <= '0;
      digit_q      <= '0;
      active_q     <= 32'h0;
      pend_val_q   <= 32'h0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= 8'hFF;
      seg_q        <= 8'hFF;
    end else begin
      enable_q     <= enable_d;
      lzs_q        <= lzs_d;
      dp_mask_q    <= dp_mask_d;
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      active_q     <= active_d;
      pend_val_q   <= pend_val_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;

endmodule
